tx_block: RTL and testbench
===========================

Name: tx_block

Overview:
- UART-style serial transmitter, the partner of rcv_block in the serial peripheral.
- Accepts a byte from the bus-side interface into a one-byte holding register.
- Sends it LSB-first on serial_out as a frame: start bit (0), 8 data bits, stop bit (1).
- Uses the same bit period as rcv_block so that a loopback to rcv_block reproduces the byte.

Parameters:
- BIT_PERIOD, 286, clocks per serial bit (must be >= 2; matches the receiver's nominal rate).

Ports:
- clk  input  1  system clock, all logic on rising edge
- n_rst  input  1  synchronous, active-low reset
- tx_data  input  8  byte to transmit
- tx_load  input  1  one-cycle strobe; writes tx_data into the holding register
- err_clear  input  1  clears write_error
- serial_out  output  1  serial line, idle high, registered
- tx_busy  output  1  high while a frame is on the line (states START/DATA/STOP)
- hold_empty  output  1  high when the holding register can accept a byte
- write_error  output  1  sticky; set when tx_load arrives while the holding register is full

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is synchronous and active-low: sampled only on a rising clk edge with n_rst = 0.
  - Reset values: serial_out = 1, tx_busy = 0, hold_empty = 1, write_error = 0, FSM = IDLE, counters = 0.
  - Reset asserted mid-frame aborts the frame. The line returns high on the next edge. Holding and shift contents are discarded.
- Holding register:
  - tx_load with hold_empty = 1 latches tx_data. hold_empty = 0 after that edge.
  - tx_load with hold_empty = 0 drops the byte and sets write_error. The held byte is unchanged.
  - write_error stays set until err_clear = 1 at an edge.
  - If set and clear occur in the same cycle, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - serial_out = 1.
    - If hold_empty = 0, copy the holding register into the shift register, set hold_empty = 1 and go to START.
    - serial_out = 0 from that same edge.
  - START: hold serial_out = 0 for exactly BIT_PERIOD clocks, then go to DATA with bit index 0.
  - DATA:
    - serial_out = shift[bit index] for BIT_PERIOD clocks per bit.
    - Bit index runs 0..7. After bit 7 go to STOP.
  - STOP:
    - serial_out = 1 for BIT_PERIOD clocks.
    - At the end: if hold_empty = 0, reload and go straight to START (no idle gap). Otherwise go to IDLE.
- Latency: tx_load sampled at edge k means hold_empty falls after edge k. serial_out falls after edge k+1.
- Frame length: exactly 10*BIT_PERIOD clocks. Back-to-back frames have a period of exactly 10*BIT_PERIOD.
- Simultaneous load and unload:
  - A tx_load at the same edge the holding register is moved to the shift register is accepted, not an error.
  - hold_empty stays 0 and write_error is not set.
- Bit timer:
  - Counts 0..BIT_PERIOD-1 and wraps to 0 at each bit boundary.
  - Width is $clog2(BIT_PERIOD).
  - Restarts at 0 on every entry to START.
- tx_busy is combinational from the FSM state (START/DATA/STOP). It is glitch-free because the state is registered.

Optional Feature:
- Macro: TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives even parity (XOR of the 8 data bits) for BIT_PERIOD clocks.
  - Frame length becomes 11*BIT_PERIOD.
  - An input parity_odd (1 bit) is added. When it is 1 the parity bit is inverted.
- When not defined: no PARITY state and no parity_odd port. Frames are 10 bits, compatible with rcv_block.

Test Plan:
- Normal frame: reset, tx_load with 0xD5, BIT_PERIOD=286 -> serial_out sequence 0,1,0,1,0,1,0,1,1,1, each level held exactly 286 clocks; tx_busy high 2860 clocks; hold_empty back to 1 one clock after load+1; write_error = 0.
- Loopback: tx_block serial_out wired to rcv_block serial_in, send 0xD5 then 0x3C -> rcv_block rx_data matches each byte, data_ready asserted, error_flag = 0.
- Back-to-back: load 0xA5, then load 0x5A during the START of 0xA5 -> second frame's start bit begins on the clock immediately after the first stop bit ends (no idle high beyond 286 clocks of stop); write_error = 0.
- Overrun: load 0x11, load 0x22 (accepted into hold), load 0x33 while hold full -> write_error = 1; line carries 0x11 then 0x22 only; err_clear pulse -> write_error = 0.
- Reset mid-frame: assert n_rst low for one clock during data bit 3 of 0xFF -> next edge serial_out = 1, tx_busy = 0, hold_empty = 1; a new load of 0x81 afterwards transmits correctly.
- Parity (TX_PARITY_EN, parity_odd=0): send 0x07 -> bit after data bit 7 = 1 for 286 clocks, frame length 3146 clocks; parity_odd=1 -> parity bit = 0.

Source files
------------

// File: rtl/tx_block.sv
// tx_block: UART-style serial transmitter with a one-byte holding register.
// Frame: start bit (0), 8 data bits sent LSB first, stop bit (1).
// Each bit lasts BIT_PERIOD clocks.
// Optional build macro TX_PARITY_EN inserts a parity bit between the data bits
// and the stop bit. The parity is even, or odd when parity_odd = 1.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | line high, waiting for the holding register to fill
//   ST_START   | start bit (0) on the line
//   ST_DATA    | data bit shift_reg[bit_idx] on the line, bit_idx 0..7
//   ST_PARITY  | parity bit on the line (TX_PARITY_EN builds only)
//   ST_STOP    | stop bit (1); reload straight into ST_START if a byte waits
module tx_block #(
    parameter int BIT_PERIOD = 286
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    input  logic       err_clear,
`ifdef TX_PARITY_EN
    input  logic       parity_odd,
`endif
    output logic       serial_out,
    output logic       tx_busy,
    output logic       hold_empty,
    output logic       write_error
);

    localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PERIOD - 1);

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
    } state_t;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [2:0]      data_sel;
    logic [7:0]      shift_reg;
    logic [7:0]      hold_reg;
    logic            bit_done;
    logic            unload;
    logic            serial_nxt;

    assign bit_done = (bit_cnt == CNT_LAST);

    // State register; serial_out is registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            serial_out <= 1'b1;
        end else begin
            state      <= state_nxt;
            serial_out <= serial_nxt;
        end
    end

    // Next-state decode; unload marks the edge that moves hold into shift.
    always_comb begin
        state_nxt = state;
        unload    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!hold_empty) begin
                    state_nxt = ST_START;
                    unload    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done && (bit_idx == 3'd7)) begin
`ifdef TX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
`ifdef TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    if (!hold_empty) begin
                        state_nxt = ST_START;
                        unload    = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: line level for the coming cycle and the busy flag.
    always_comb begin
        serial_nxt = 1'b1;
        data_sel   = (state == ST_DATA && bit_done) ? bit_idx + 3'd1 : bit_idx;
        tx_busy    = (state != ST_IDLE);
        case (state_nxt)
            ST_START:  serial_nxt = 1'b0;
            ST_DATA:   serial_nxt = shift_reg[data_sel];
`ifdef TX_PARITY_EN
            ST_PARITY: serial_nxt = (^shift_reg) ^ parity_odd;
`endif
            default:   serial_nxt = 1'b1;
        endcase
    end

    // Bit timer wraps at every bit boundary; it holds at 0 in idle, so each
    // start bit begins at 0. The bit index only advances inside DATA.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            bit_cnt   <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            if (state == ST_IDLE || bit_done) bit_cnt <= '0;
            else                              bit_cnt <= bit_cnt + CW'(1);
            if (state == ST_DATA) begin
                if (bit_done) bit_idx <= bit_idx + 3'd1;
            end else begin
                bit_idx <= 3'd0;
            end
            if (unload) shift_reg <= hold_reg;
        end
    end

    // Holding register and sticky overrun flag. A load on the unload edge is
    // accepted. If an overrun and err_clear happen together, the overrun wins.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            hold_reg    <= 8'h00;
            hold_empty  <= 1'b1;
            write_error <= 1'b0;
        end else begin
            if (tx_load && (hold_empty || unload)) begin
                hold_reg   <= tx_data;
                hold_empty <= 1'b0;
            end else if (unload) begin
                hold_empty <= 1'b1;
            end
            if (tx_load && !hold_empty && !unload) write_error <= 1'b1;
            else if (err_clear)                    write_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_block.sv
module tb_tx_block;

    localparam int BP = 286;
`ifdef TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       tb_clk = 1'b0;
    logic       n_rst;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       err_clear;
`ifdef TX_PARITY_EN
    logic       parity_odd_drv;
`endif
    logic       serial_out;
    logic       tx_busy;
    logic       hold_empty;
    logic       write_error;

    int vec_cnt = 0;
    int err_cnt = 0;

    tx_block #(.BIT_PERIOD(BP)) dut (
        .clk        (tb_clk),
        .n_rst      (n_rst),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .err_clear  (err_clear),
`ifdef TX_PARITY_EN
        .parity_odd (parity_odd_drv),
`endif
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .hold_empty (hold_empty),
        .write_error(write_error)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    // Drive a one-cycle load strobe. The edge that samples it has passed on return.
    task automatic load_byte(input logic [7:0] b);
        tx_data = b;
        tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
    endtask

    // The current sample is a start-bit clock, with pre start clocks already seen.
    // Each line level must hold for its full period while tx_busy stays high.
    task automatic check_frame(input logic [7:0] b, input int pre, input string nm);
        logic [NB-1:0] lv;
        lv[0]   = 1'b0;
        lv[8:1] = b;
`ifdef TX_PARITY_EN
        lv[9]   = (^b) ^ parity_odd_drv;
        lv[10]  = 1'b1;
`else
        lv[9]   = 1'b1;
`endif
        for (int k = 0; k < NB; k++) begin
            int bad = 0;
            int len = (k == 0) ? BP - pre : BP;
            for (int i = 0; i < len; i++) begin
                if (serial_out !== lv[k] || tx_busy !== 1'b1) bad++;
                tick();
            end
            vec_cnt++;
            if (bad != 0) begin
                err_cnt++;
                $display("FAIL %s frame bit %0d: %0d of %0d clocks wrong, required serial_out=%b tx_busy=1",
                         nm, k, bad, len, lv[k]);
            end
        end
    endtask

    task automatic check_idle(input string nm);
        vec_cnt++;
        if (serial_out !== 1'b1 || tx_busy !== 1'b0 || hold_empty !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s idle: serial_out=%b tx_busy=%b hold_empty=%b, required 1 0 1",
                     nm, serial_out, tx_busy, hold_empty);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0; tx_data = 8'h00; tx_load = 1'b0; err_clear = 1'b0;
`ifdef TX_PARITY_EN
        parity_odd_drv = 1'b0;
`endif
        tick(); tick();
        check_idle("reset");
        vec_cnt++;
        if (write_error !== 1'b0) begin
            err_cnt++; $display("FAIL reset write_error: got %b, required 0", write_error);
        end
        n_rst = 1'b1;
        tick(); tick();
        check_idle("post_reset");
    endtask

    task automatic test_normal_frame();
        load_byte(8'hD5);
        vec_cnt++;
        if (hold_empty !== 1'b0 || serial_out !== 1'b1 || tx_busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL normal load edge: hold_empty=%b serial_out=%b tx_busy=%b, required 0 1 0",
                     hold_empty, serial_out, tx_busy);
        end
        tick();
        vec_cnt++;
        if (hold_empty !== 1'b1 || serial_out !== 1'b0 || tx_busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL normal start edge: hold_empty=%b serial_out=%b tx_busy=%b, required 1 0 1",
                     hold_empty, serial_out, tx_busy);
        end
        check_frame(8'hD5, 0, "normal_d5");
        check_idle("normal_end");
        vec_cnt++;
        if (write_error !== 1'b0) begin
            err_cnt++; $display("FAIL normal write_error: got %b, required 0", write_error);
        end
    endtask

    // Independent receiver: find the falling edge, then sample each bit at its centre.
    task automatic rx_capture(output logic [7:0] d, output logic frame_ok, output logic timed_out);
        int t = 0;
        logic st, sp;
        d = 8'h00; frame_ok = 1'b0; timed_out = 1'b0;
        while (serial_out !== 1'b0 && t < 5000) begin
            tick(); t++;
        end
        if (t >= 5000) begin
            timed_out = 1'b1;
            return;
        end
        repeat (BP / 2) tick();
        st = serial_out;
        for (int i = 0; i < 8; i++) begin
            repeat (BP) tick();
            d[i] = serial_out;
        end
`ifdef TX_PARITY_EN
        repeat (BP) tick();
`endif
        repeat (BP) tick();
        sp = serial_out;
        frame_ok = (st === 1'b0) && (sp === 1'b1);
        repeat (BP - BP / 2) tick();
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [2];
        logic [7:0] got;
        logic ok, to;
        bytes[0] = 8'hD5;
        bytes[1] = 8'h3C;
        for (int n = 0; n < 2; n++) begin
            load_byte(bytes[n]);
            rx_capture(got, ok, to);
            vec_cnt++;
            if (to) begin
                err_cnt++; $display("FAIL loopback %0d: no start bit within 5000 clocks", n);
            end else if (got !== bytes[n] || ok !== 1'b1) begin
                err_cnt++;
                $display("FAIL loopback %0d: received %h framing_ok=%b, required %h framing_ok=1",
                         n, got, ok, bytes[n]);
            end
        end
        check_idle("loopback_end");
    endtask

    task automatic test_back_to_back();
        load_byte(8'hA5);
        tick();
        tx_data = 8'h5A;
        tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        vec_cnt++;
        if (hold_empty !== 1'b0 || serial_out !== 1'b0 || write_error !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b second load: hold_empty=%b serial_out=%b write_error=%b, required 0 0 0",
                     hold_empty, serial_out, write_error);
        end
        check_frame(8'hA5, 1, "b2b_a5");
        check_frame(8'h5A, 0, "b2b_5a");
        check_idle("b2b_end");
        vec_cnt++;
        if (write_error !== 1'b0) begin
            err_cnt++; $display("FAIL b2b write_error: got %b, required 0", write_error);
        end
    endtask

    task automatic test_overrun();
        load_byte(8'h11);
        tx_data = 8'h22;
        tx_load = 1'b1;
        tick();
        vec_cnt++;
        if (hold_empty !== 1'b0 || write_error !== 1'b0 || serial_out !== 1'b0) begin
            err_cnt++;
            $display("FAIL overrun load on unload edge: hold_empty=%b write_error=%b serial_out=%b, required 0 0 0",
                     hold_empty, write_error, serial_out);
        end
        tx_data   = 8'h33;
        err_clear = 1'b1;
        tick();
        tx_load   = 1'b0;
        err_clear = 1'b0;
        vec_cnt++;
        if (write_error !== 1'b1 || hold_empty !== 1'b0) begin
            err_cnt++;
            $display("FAIL overrun set with clear: write_error=%b hold_empty=%b, required 1 0",
                     write_error, hold_empty);
        end
        check_frame(8'h11, 1, "overrun_11");
        check_frame(8'h22, 0, "overrun_22");
        check_idle("overrun_end");
        vec_cnt++;
        if (write_error !== 1'b1) begin
            err_cnt++; $display("FAIL overrun sticky: write_error=%b, required 1", write_error);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        vec_cnt++;
        if (write_error !== 1'b0) begin
            err_cnt++; $display("FAIL err_clear: write_error=%b, required 0", write_error);
        end
    endtask

    task automatic test_reset_mid_frame();
        load_byte(8'hFF);
        tick();
        repeat (BP * 4 + 100) tick();
        vec_cnt++;
        if (serial_out !== 1'b1 || tx_busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL midframe data bit 3: serial_out=%b tx_busy=%b, required 1 1", serial_out, tx_busy);
        end
        load_byte(8'h42);
        vec_cnt++;
        if (hold_empty !== 1'b0) begin
            err_cnt++; $display("FAIL midframe hold fill: hold_empty=%b, required 0", hold_empty);
        end
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        check_idle("midframe_reset");
        repeat (10) tick();
        check_idle("midframe_after");
        load_byte(8'h81);
        tick();
        check_frame(8'h81, 0, "midframe_81");
        check_idle("midframe_end");
    endtask

`ifdef TX_PARITY_EN
    task automatic test_parity();
        parity_odd_drv = 1'b0;
        load_byte(8'h07);
        tick();
        check_frame(8'h07, 0, "parity_even_07");
        check_idle("parity_even_end");
        parity_odd_drv = 1'b1;
        load_byte(8'h07);
        tick();
        check_frame(8'h07, 0, "parity_odd_07");
        check_idle("parity_odd_end");
        parity_odd_drv = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_normal_frame();
        test_loopback();
        test_back_to_back();
        test_overrun();
        test_reset_mid_frame();
`ifdef TX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
